// File: rtl/debug_ocimem_ctrl.sv
// Debug on-chip memory controller: JTAG debug access and a CPU
// Avalon-MM slave sharing one single-port 32-bit RAM.
module debug_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              mon_valid,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic              avs_waitrequest,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid
);

  typedef enum logic [1:0] {IDLE, J_RD, C_RD} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_A, OP_B, OP_N} op_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_ptr, ptr_nxt;

  logic              pend_v;
  op_t               pend_op;
  logic [37:0]       pend_jdo;

  op_t               strobe_op, op;
  logic [37:0]       op_jdo;
  logic              any_strobe, consume, load_pend;

  logic              ram_we, ram_re;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_q;
  logic [31:0]       mem [2**ADDR_W];

  logic              unused_jdo_bits;

  assign unused_jdo_bits = ^{op_jdo[37:35], op_jdo[2:0]};

  // Fixed strobe priority: a > b > no_action_a.
  always_comb begin
    strobe_op = OP_NONE;
    if (take_action_ocimem_a)         strobe_op = OP_A;
    else if (take_action_ocimem_b)    strobe_op = OP_B;
    else if (take_no_action_ocimem_a) strobe_op = OP_N;
  end

  assign any_strobe = (strobe_op != OP_NONE);

  assign avs_waitrequest = reset | (state != IDLE)
                         | any_strobe | pend_v;

  // Next state, RAM port control, pointer and pending-slot control.
  // Any debug read, including the one from take_action_a,
  // advances the pointer so successive reads stream through RAM.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = addr_ptr;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_be    = 4'h0;
    ram_addr  = addr_ptr;
    ram_wdata = 32'h0;
    op        = OP_NONE;
    op_jdo    = jdo;
    consume   = 1'b0;
    load_pend = any_strobe && !pend_v && (state != IDLE);
    case (state)
      IDLE: begin
        if (pend_v) begin
          op      = pend_op;
          op_jdo  = pend_jdo;
          consume = 1'b1;
        end else if (!reset) begin
          op = strobe_op;
        end
        case (op)
          OP_A: begin
            ptr_nxt = op_jdo[17 +: ADDR_W];
            if (op_jdo[34]) begin
              ram_re    = 1'b1;
              ram_addr  = op_jdo[17 +: ADDR_W];
              ptr_nxt   = op_jdo[17 +: ADDR_W] + ADDR_W'(1);
              state_nxt = J_RD;
            end
          end
          OP_B: begin
            ram_we    = 1'b1;
            ram_be    = 4'hF;
            ram_wdata = op_jdo[34:3];
            ptr_nxt   = addr_ptr + ADDR_W'(1);
          end
          OP_N: begin
            ram_re    = 1'b1;
            ptr_nxt   = addr_ptr + ADDR_W'(1);
            state_nxt = J_RD;
          end
          default: begin
            if (!avs_waitrequest) begin
              if (avs_write) begin
                ram_we    = 1'b1;
                ram_be    = avs_byteenable;
                ram_addr  = avs_address;
                ram_wdata = avs_writedata;
              end else if (avs_read) begin
                ram_re    = 1'b1;
                ram_addr  = avs_address;
                state_nxt = C_RD;
              end
            end
          end
        endcase
      end
      J_RD:    state_nxt = IDLE;
      C_RD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, pending slot and the registered read outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      addr_ptr          <= '0;
      pend_v            <= 1'b0;
      pend_op           <= OP_NONE;
      pend_jdo          <= '0;
      MonDReg           <= '0;
      mon_valid         <= 1'b0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      state             <= state_nxt;
      addr_ptr          <= ptr_nxt;
      mon_valid         <= (state == J_RD);
      avs_readdatavalid <= (state == C_RD);
      if (state == J_RD) MonDReg <= ram_q;
      if (state == C_RD) avs_readdata <= ram_q;
      if (consume) begin
        pend_v <= 1'b0;
      end else if (load_pend) begin
        pend_v   <= 1'b1;
        pend_op  <= strobe_op;
        pend_jdo <= jdo;
      end
    end
  end

  // Single-port RAM with byte-lane writes and registered read.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    if (ram_re) ram_q <= mem[ram_addr];
  end

endmodule

// File: tb/tb_debug_ocimem_ctrl.sv
// Self-checking bench for debug_ocimem_ctrl: directed scenarios plus
// randomized JTAG/CPU traffic against a word-array memory model.
module tb_debug_ocimem_ctrl;

  localparam int AW  = 8;
  localparam int K_A = 1;
  localparam int K_B = 2;
  localparam int K_N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [37:0]   jdo;
  logic          ta_a, ta_b, tn_a;
  logic [31:0]   MonDReg;
  logic          mon_valid;
  logic [AW-1:0] avs_address;
  logic          avs_read, avs_write;
  logic [31:0]   avs_writedata;
  logic [3:0]    avs_byteenable;
  logic          avs_waitrequest;
  logic [31:0]   avs_readdata;
  logic          avs_readdatavalid;

  int errors = 0;
  int checks = 0;

  logic [31:0] mm [256];
  int          ptr_m = 0;

  debug_ocimem_ctrl #(.ADDR_W(AW)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_action_ocimem_b    (ta_b),
    .take_no_action_ocimem_a (tn_a),
    .MonDReg                 (MonDReg),
    .mon_valid               (mon_valid),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_waitrequest         (avs_waitrequest),
    .avs_readdata            (avs_readdata),
    .avs_readdatavalid       (avs_readdatavalid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] mk_a(input logic [7:0] a, input bit rd);
    logic [37:0] j;
    j = 38'({$urandom(), $urandom()});
    j[24:17] = a;
    j[34] = rd;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = 38'({$urandom(), $urandom()});
    j[34:3] = d;
    return j;
  endfunction

  // Reference model: debug command semantics on a word array.
  function automatic void model_jtag(input int k, input logic [37:0] j,
                                     output bit rd, output logic [31:0] e);
    rd = 1'b0;
    e  = 32'h0;
    if (k == K_A) begin
      ptr_m = int'(j[24:17]);
      if (j[34]) begin
        rd    = 1'b1;
        e     = mm[ptr_m];
        ptr_m = (ptr_m + 1) % 256;
      end
    end else if (k == K_B) begin
      mm[ptr_m] = j[34:3];
      ptr_m     = (ptr_m + 1) % 256;
    end else begin
      rd    = 1'b1;
      e     = mm[ptr_m];
      ptr_m = (ptr_m + 1) % 256;
    end
  endfunction

  function automatic void model_cpu_write(input logic [7:0] a,
                                          input logic [31:0] d,
                                          input logic [3:0] be);
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mm[a][8*i +: 8] = d[8*i +: 8];
    end
  endfunction

  // Pulse strobes (mask {n,b,a}) for one cycle, then watch mon_valid.
  task automatic jtag_op(input int mask, input logic [37:0] j,
                         output int pulses, output int lat,
                         output logic [31:0] d);
    jdo  = j;
    ta_a = (mask & K_A) != 0;
    ta_b = (mask & K_B) != 0;
    tn_a = (mask & K_N) != 0;
    step();
    ta_a = 1'b0;
    ta_b = 1'b0;
    tn_a = 1'b0;
    pulses = 0;
    lat    = -1;
    d      = 32'h0;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) step();
      if (mon_valid === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = c;
          d   = MonDReg;
        end
      end
    end
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] be, output bit ok);
    avs_address    = a;
    avs_writedata  = d;
    avs_byteenable = be;
    avs_write      = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 8 && !ok; c++) begin
      #1;
      ok = (avs_waitrequest === 1'b0);
      step();
    end
    avs_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output bit ok,
                          output int pulses, output int lat,
                          output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 8 && !ok; c++) begin
      #1;
      ok = (avs_waitrequest === 1'b0);
      step();
    end
    avs_read = 1'b0;
    pulses = 0;
    lat    = -1;
    d      = 32'h0;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) step();
      if (avs_readdatavalid === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = c;
          d   = avs_readdata;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    jdo = '0; ta_a = 0; ta_b = 0; tn_a = 0;
    avs_address = '0; avs_read = 0; avs_write = 0;
    avs_writedata = '0; avs_byteenable = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (avs_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait got=%b exp=1", avs_waitrequest);
    end
    checks++;
    if (MonDReg !== 32'h0) begin
      errors++;
      $display("FAIL reset_mondreg got=%h exp=0", MonDReg);
    end
    checks++;
    if (mon_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mon_valid got=%b exp=0", mon_valid);
    end
    checks++;
    if (avs_readdatavalid !== 1'b0 || avs_readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_avs got=%b/%h exp=0/0",
               avs_readdatavalid, avs_readdata);
    end
    reset = 1'b0;
    ptr_m = 0;
    #1;
    checks++;
    if (avs_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL idle_wait got=%b exp=0", avs_waitrequest);
    end
    step();
  endtask

  task automatic test_write_inc();
    logic [37:0] j;
    logic [31:0] d, e;
    int p, l;
    bit rd;
    logic [31:0] wv [4];
    wv[0] = 32'h11111111; wv[1] = 32'h22222222;
    wv[2] = 32'h33333333; wv[3] = 32'h44444444;
    j = mk_a(8'h10, 1'b0);
    model_jtag(K_A, j, rd, e);
    jtag_op(K_A, j, p, l, d);
    checks++;
    if (p !== 0 || MonDReg !== 32'h0) begin
      errors++;
      $display("FAIL set_addr pulses=%0d mon=%h exp=0/0", p, MonDReg);
    end
    for (int i = 0; i < 4; i++) begin
      j = mk_b(wv[i]);
      model_jtag(K_B, j, rd, e);
      jtag_op(K_B, j, p, l, d);
      checks++;
      if (p !== 0) begin
        errors++;
        $display("FAIL write_no_pulse[%0d] pulses=%0d exp=0", i, p);
      end
    end
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (i == 0) ? K_A : K_N;
      j = (i == 0) ? mk_a(8'h10, 1'b1) : 38'h0;
      model_jtag(k, j, rd, e);
      jtag_op(k, j, p, l, d);
      checks++;
      if (d !== wv[i] || d !== e || p != 1 || l != 1) begin
        errors++;
        $display("FAIL stream_read[%0d] got=%h p=%0d l=%0d exp=%h p=1 l=1",
                 i, d, p, l, wv[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [37:0] j;
    logic [31:0] d, e;
    int p, l;
    bit rd;
    j = mk_a(8'h00, 1'b0); model_jtag(K_A, j, rd, e); jtag_op(K_A, j, p, l, d);
    j = mk_b(32'hCAFE0000); model_jtag(K_B, j, rd, e); jtag_op(K_B, j, p, l, d);
    j = mk_a(8'hFF, 1'b0); model_jtag(K_A, j, rd, e); jtag_op(K_A, j, p, l, d);
    j = mk_b(32'h5A5AA5A5); model_jtag(K_B, j, rd, e); jtag_op(K_B, j, p, l, d);
    j = 38'h0; model_jtag(K_N, j, rd, e); jtag_op(K_N, j, p, l, d);
    checks++;
    if (d !== 32'hCAFE0000 || d !== e || p != 1) begin
      errors++;
      $display("FAIL wrap_ptr got=%h exp=cafe0000", d);
    end
    j = mk_a(8'hFF, 1'b1); model_jtag(K_A, j, rd, e); jtag_op(K_A, j, p, l, d);
    checks++;
    if (d !== 32'h5A5AA5A5 || d !== e) begin
      errors++;
      $display("FAIL wrap_data got=%h exp=5a5aa5a5", d);
    end
  endtask

  task automatic test_cpu_bytes();
    bit ok1, ok2, ok3;
    int p, l;
    logic [31:0] d;
    cpu_write(8'h20, 32'h0, 4'hF, ok1);
    model_cpu_write(8'h20, 32'h0, 4'hF);
    cpu_write(8'h20, 32'hAABBCCDD, 4'b0101, ok2);
    model_cpu_write(8'h20, 32'hAABBCCDD, 4'b0101);
    cpu_read(8'h20, ok3, p, l, d);
    checks++;
    if (!(ok1 && ok2 && ok3)) begin
      errors++;
      $display("FAIL cpu_accept got=%b%b%b exp=111", ok1, ok2, ok3);
    end
    checks++;
    if (d !== 32'h00BB00DD || d !== mm[8'h20]) begin
      errors++;
      $display("FAIL cpu_byteen got=%h exp=00bb00dd", d);
    end
    checks++;
    if (p != 1 || l != 1) begin
      errors++;
      $display("FAIL cpu_rdv pulses=%0d lat=%0d exp=1/1", p, l);
    end
  endtask

  task automatic test_contention();
    logic [37:0] j;
    logic [31:0] d, e_dbg, e_cpu, mon_d, rdv_d;
    int p, l, mon_c, rdv_c, mon_n, rdv_n;
    bit rd;
    logic w;
    j = mk_a(8'h10, 1'b0); model_jtag(K_A, j, rd, e_dbg);
    jtag_op(K_A, j, p, l, d);
    e_cpu = mm[8'h20];
    jdo = 38'h0;
    model_jtag(K_N, jdo, rd, e_dbg);
    tn_a = 1'b1;
    avs_address = 8'h20;
    avs_read = 1'b1;
    #1;
    checks++;
    if (avs_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL contend_wait got=%b exp=1", avs_waitrequest);
    end
    mon_c = -1; rdv_c = -1; mon_n = 0; rdv_n = 0;
    mon_d = 32'h0; rdv_d = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      w = avs_waitrequest;
      step();
      tn_a = 1'b0;
      if (avs_read && w === 1'b0) avs_read = 1'b0;
      if (mon_valid === 1'b1) begin
        mon_n++;
        if (mon_c < 0) begin mon_c = c; mon_d = MonDReg; end
      end
      if (avs_readdatavalid === 1'b1) begin
        rdv_n++;
        if (rdv_c < 0) begin rdv_c = c; rdv_d = avs_readdata; end
      end
      #1;
    end
    avs_read = 1'b0;
    checks++;
    if (mon_d !== e_dbg || mon_n != 1 || mon_c != 2) begin
      errors++;
      $display("FAIL contend_dbg got=%h n=%0d c=%0d exp=%h n=1 c=2",
               mon_d, mon_n, mon_c, e_dbg);
    end
    checks++;
    if (rdv_d !== e_cpu || rdv_n != 1 || rdv_c <= mon_c) begin
      errors++;
      $display("FAIL contend_cpu got=%h n=%0d c=%0d exp=%h n=1 after %0d",
               rdv_d, rdv_n, rdv_c, e_cpu, mon_c);
    end
  endtask

  task automatic test_pending();
    logic [37:0] j;
    logic [31:0] d, e, e_n, dv;
    int p, l;
    bit rd;
    dv = $urandom();
    jdo = 38'h0;
    model_jtag(K_N, jdo, rd, e_n);
    tn_a = 1'b1;
    step();
    tn_a = 1'b0;
    j = mk_b(dv);
    model_jtag(K_B, j, rd, e);
    jdo = j;
    ta_b = 1'b1;
    step();
    checks++;
    if (mon_valid !== 1'b1 || MonDReg !== e_n) begin
      errors++;
      $display("FAIL pend_read got=%b/%h exp=1/%h", mon_valid, MonDReg, e_n);
    end
    jdo = mk_b(~dv);
    step();
    ta_b = 1'b0;
    repeat (3) step();
    j = mk_a(8'(ptr_m - 1), 1'b1);
    model_jtag(K_A, j, rd, e);
    jtag_op(K_A, j, p, l, d);
    checks++;
    if (d !== dv || d !== e) begin
      errors++;
      $display("FAIL pend_exec got=%h exp=%h", d, dv);
    end
    j = 38'h0;
    model_jtag(K_N, j, rd, e);
    jtag_op(K_N, j, p, l, d);
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL pend_drop got=%h exp=%h", d, e);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [37:0] j;
    logic [31:0] d, e;
    int p, l, n;
    bit rd;
    jdo = mk_a(8'h10, 1'b1);
    ta_a = 1'b1;
    step();
    ta_a = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (MonDReg !== 32'h0 || mon_valid !== 1'b0 || avs_waitrequest !== 1'b1
        || avs_readdata !== 32'h0 || avs_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL midrd_reset got=%h/%b/%b/%h/%b exp=0/0/1/0/0",
               MonDReg, mon_valid, avs_waitrequest, avs_readdata,
               avs_readdatavalid);
    end
    step();
    step();
    reset = 1'b0;
    ptr_m = 0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      if (mon_valid === 1'b1) n++;
      step();
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL midrd_no_pulse got=%0d exp=0", n);
    end
    j = 38'h0;
    model_jtag(K_N, j, rd, e);
    jtag_op(K_N, j, p, l, d);
    checks++;
    if (d !== 32'hCAFE0000 || d !== e) begin
      errors++;
      $display("FAIL midrd_ptr got=%h exp=cafe0000", d);
    end
  endtask

  task automatic test_priority();
    logic [37:0] j;
    logic [31:0] d, e;
    int p, l;
    bit rd;
    for (int i = 0; i < 256; i++) begin
      j = (i == 0) ? mk_a(8'h00, 1'b0) : 38'h0;
      if (i == 0) begin
        model_jtag(K_A, j, rd, e);
        jtag_op(K_A, j, p, l, d);
      end
      j = mk_b($urandom());
      model_jtag(K_B, j, rd, e);
      jtag_op(K_B, j, p, l, d);
    end
    j = mk_a(8'($urandom_range(0, 255)), 1'b0);
    model_jtag(K_A, j, rd, e);
    jtag_op(K_A | K_B | K_N, j, p, l, d);
    checks++;
    if (p != 0) begin
      errors++;
      $display("FAIL prio_a_pulses got=%0d exp=0", p);
    end
    j = 38'h0;
    model_jtag(K_N, j, rd, e);
    jtag_op(K_N, j, p, l, d);
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL prio_a got=%h exp=%h", d, e);
    end
    j = mk_b($urandom());
    model_jtag(K_B, j, rd, e);
    jtag_op(K_B | K_N, j, p, l, d);
    checks++;
    if (p != 0) begin
      errors++;
      $display("FAIL prio_b_pulses got=%0d exp=0", p);
    end
    j = mk_a(8'(ptr_m - 1), 1'b1);
    model_jtag(K_A, j, rd, e);
    jtag_op(K_A, j, p, l, d);
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL prio_b got=%h exp=%h", d, e);
    end
  endtask

  task automatic test_random();
    logic [37:0] j;
    logic [31:0] d, e, wd;
    logic [7:0] a;
    logic [3:0] be;
    int p, l, k;
    bit rd, ok;
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 4);
      if (k <= 2) begin
        k = (k == 0) ? K_A : (k == 1) ? K_B : K_N;
        if (k == K_A) j = mk_a(8'($urandom()), 1'($urandom()));
        else if (k == K_B) j = mk_b($urandom());
        else j = 38'({$urandom(), $urandom()});
        model_jtag(k, j, rd, e);
        jtag_op(k, j, p, l, d);
        checks++;
        if (rd && (d !== e || p != 1 || l != 1)) begin
          errors++;
          $display("FAIL rnd_jtag[%0d] k=%0d got=%h p=%0d l=%0d exp=%h",
                   i, k, d, p, l, e);
        end else if (!rd && p != 0) begin
          errors++;
          $display("FAIL rnd_jtag_pulse[%0d] k=%0d got=%0d exp=0", i, k, p);
        end
      end else if (k == 3) begin
        a = 8'($urandom());
        wd = $urandom();
        be = 4'($urandom());
        cpu_write(a, wd, be, ok);
        model_cpu_write(a, wd, be);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL rnd_cpu_wr[%0d] accepted=%b exp=1", i, ok);
        end
      end else begin
        a = 8'($urandom());
        cpu_read(a, ok, p, l, d);
        checks++;
        if (!ok || d !== mm[a] || p != 1 || l != 1) begin
          errors++;
          $display("FAIL rnd_cpu_rd[%0d] a=%h got=%h p=%0d l=%0d exp=%h",
                   i, a, d, p, l, mm[a]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_inc();
    test_wrap();
    test_cpu_bytes();
    test_contention();
    test_pending();
    test_reset_mid_read();
    test_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_ocimem_ctrl.md
Name: debug_ocimem_ctrl

Overview:
- System-clock-domain on-chip debug memory controller, directly downstream of the debug slave wrapper.
- Consumes the wrapper's jdo command word and its ocimem take_action strobes; performs debug reads/writes on a single-port debug RAM.
- Returns read data on MonDReg, which feeds back into the wrapper for JTAG shift-out.
- Also arbitrates a CPU Avalon-MM slave port onto the same RAM; JTAG accesses take priority.

Parameters:
ADDR_W, 8, RAM word-address width (depth 2^ADDR_W words of 32 bits); legal range 4..10.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
jdo  in  38  debug command/data word; stable whenever a strobe is high
take_action_ocimem_a  in  1  one-cycle strobe: set address, optional read
take_action_ocimem_b  in  1  one-cycle strobe: write data, post-increment
take_no_action_ocimem_a  in  1  one-cycle strobe: read, post-increment
MonDReg  out  32  last debug read data
mon_valid  out  1  one-cycle pulse when MonDReg is updated
avs_address  in  ADDR_W  CPU word address
avs_read  in  1  CPU read request
avs_write  in  1  CPU write request
avs_writedata  in  32  CPU write data
avs_byteenable  in  4  CPU byte lanes
avs_waitrequest  out  1  CPU stall
avs_readdata  out  32  CPU read data
avs_readdatavalid  out  1  CPU read data valid pulse

Behaviour:
- Reset (async assert, sync release): state=IDLE, addr_ptr=0, pending=0, MonDReg=0, mon_valid=0, avs_readdatavalid=0, avs_readdata=0, avs_waitrequest=1. RAM contents are not reset.
- RAM: single port, registered read, 1-cycle latency.
- FSM states are IDLE, J_RD and C_RD.
- Strobe priority if several strobes assert in the same cycle: take_action_ocimem_a > take_action_ocimem_b > take_no_action_ocimem_a.
- take_action_ocimem_a:
  - addr_ptr <= jdo[17 +: ADDR_W].
  - If jdo[34]=1, also issue a read at the new address and go to J_RD. Otherwise stay in IDLE.
- take_action_ocimem_b:
  - Write jdo[34:3] to mem[addr_ptr] with all bytes enabled.
  - addr_ptr <= addr_ptr+1, wrapping modulo 2^ADDR_W (e.g. 0xFF -> 0x00).
  - Remains in IDLE.
- take_no_action_ocimem_a:
  - Read mem[addr_ptr], go to J_RD, addr_ptr <= addr_ptr+1 (wrapping).
- J_RD timing:
  - Read issued at edge t.
  - Data is on the RAM output during cycle t+1. MonDReg loads it at edge t+1.
  - mon_valid is high for one cycle after edge t+1. MonDReg holds until the next debug read.
  - J_RD -> IDLE after one cycle.
- Strobe arriving while not IDLE:
  - Latched into a one-entry pending register (strobe type plus jdo).
  - Executed on the first IDLE cycle, ahead of any CPU request.
  - A second strobe while pending is full is dropped.
- CPU port:
  - avs_waitrequest = reset | state!=IDLE | any strobe | pending.
  - Write accepted in one cycle when waitrequest is low; byteenable masks the lanes.
  - Read accepted at edge t -> state C_RD. avs_readdata is valid and avs_readdatavalid is high for exactly one cycle after edge t+1. C_RD -> IDLE.
  - avs_read and avs_write asserted together with waitrequest low: write wins and the read is ignored.
  - The CPU holds its request while waitrequest=1.
- Simultaneous JTAG strobe and CPU request: JTAG executes and the CPU sees waitrequest=1 that cycle.
- Reset mid-read: the read is abandoned. No mon_valid and no avs_readdatavalid pulse are produced. addr_ptr returns to 0.

Test Plan:
- Reset release, then take_action_ocimem_a with jdo[17+:8]=0x10 and jdo[34]=0 -> addr_ptr=0x10, no mon_valid, MonDReg=0.
- After that, take_action_ocimem_b three times with data 0x11111111, 0x22222222, 0x33333333 -> mem[0x10..0x12] written, addr_ptr=0x13.
- take_action_ocimem_a to 0x10 with jdo[34]=1, then two take_no_action_ocimem_a -> MonDReg = 0x11111111, 0x22222222, 0x33333333 in turn, one mon_valid pulse each, one cycle after the strobe's issue edge.
- addr_ptr=0xFF, take_action_ocimem_b -> mem[0xFF] written and addr_ptr wraps to 0x00.
- CPU write 0xAABBCCDD to 0x20 with byteenable=4'b0101, then CPU read 0x20 (prior contents 0) -> avs_readdata=0x00BB00DD with a single avs_readdatavalid pulse.
- CPU read asserted in the same cycle as take_no_action_ocimem_a -> avs_waitrequest high; debug read completes first; CPU read then completes with the correct data.
- reset asserted during J_RD -> no mon_valid; all outputs return to their reset values immediately.
